// File: rtl/router_flit_scheduler.sv
// router_flit_scheduler: credit-based flit router, 3 outputs + discard port; ROUTER_SCHED_STATS_EN adds a packet counter.
module router_flit_scheduler #(
  parameter int DATA_W  = 8,
  parameter int CREDITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_port,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [2:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic [2:0]        credit_ret,
  output logic              credit_err,
  output logic [15:0]       pkt_count
);
  typedef enum logic [1:0] {HEAD, BODY, DROP} state_t;
  localparam logic [3:0] CMAX = 4'(CREDITS);
  state_t     state, state_n;
  logic [1:0] cur_port, tgt;
  logic [3:0] credit [3];
  logic [3:0] avail;
  logic [2:0] consume, ovf;
  logic       discard, accept, fwd;
  always_comb begin
    avail = {1'b0, credit[2] != 0, credit[1] != 0, credit[0] != 0};
    tgt = state == HEAD ? in_port : cur_port;
    discard = state == DROP || (state == HEAD && in_port == 2'd3);
    in_ready = discard || avail[tgt];
    accept = in_valid && in_ready;
    fwd = accept && !discard;
    consume = {3{fwd}} & (3'b001 << tgt);
    for (int i = 0; i < 3; i++) ovf[i] = credit_ret[i] && !consume[i] && credit[i] == CMAX;
    state_n = !accept ? state :
              in_last ? HEAD :
              state != HEAD ? state :
              in_port == 2'd3 ? DROP : BODY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HEAD;
      cur_port   <= '0;
      out_valid  <= '0;
      out_data   <= '0;
      out_last   <= 1'b0;
      credit_err <= 1'b0;
      for (int i = 0; i < 3; i++) credit[i] <= CMAX;
    end else begin
      state      <= state_n;
      out_valid  <= consume;
      credit_err <= credit_err || |ovf;
      if (state == HEAD && accept) cur_port <= in_port;
      if (fwd) begin
        out_data <= in_data;
        out_last <= in_last;
      end
      for (int i = 0; i < 3; i++)
        if (credit_ret[i] && !consume[i] && !ovf[i]) credit[i] <= credit[i] + 4'd1;
        else if (consume[i] && !credit_ret[i]) credit[i] <= credit[i] - 4'd1;
    end
  end
`ifdef ROUTER_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) pkt_count <= '0;
    else if (fwd && in_last) pkt_count <= pkt_count + 16'd1;
  end
`else
  assign pkt_count = '0;
`endif
endmodule

// File: tb/tb_router_flit_scheduler.sv
// tb_router_flit_scheduler: table-driven directed checks of router_flit_scheduler (CREDITS=4).
module tb_router_flit_scheduler;
  logic       clk = 0, rst = 1, in_valid = 0, in_last = 0, in_ready, out_last, credit_err;
  logic [1:0] in_port = 0;
  logic [7:0] in_data = 0, out_data;
  logic [2:0] credit_ret = 0, out_valid;
  logic [15:0] pkt_count;
  int n_chk = 0, n_fail = 0;

  router_flit_scheduler #(.DATA_W(8), .CREDITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_port(in_port),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .credit_ret(credit_ret), .credit_err(credit_err), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, v;
    logic [1:0] p;
    logic [7:0] d;
    logic       l;
    logic [2:0] ret;
    logic       ck, rdy;
    logic [2:0] ov;
    logic [7:0] od;
    logic       ol, err;
  } vec_t;

  vec_t tv [43];

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(logic r, logic v, logic [1:0] p, logic [7:0] d, logic l, logic [2:0] ret,
                              logic ck, logic rdy, logic [2:0] ov, logic [7:0] od, logic ol, logic err);
    vec_t t;
    t.r = r; t.v = v; t.p = p; t.d = d; t.l = l; t.ret = ret;
    t.ck = ck; t.rdy = rdy; t.ov = ov; t.od = od; t.ol = ol; t.err = err;
    return t;
  endfunction

  initial begin
    //           r  v  p  d      l  ret     ck rdy ov      od     ol err
    tv[0]  = mk(1, 0, 0, 8'h00, 0, 3'b000, 0, 0, 3'b000, 8'h00, 0, 0);
    tv[1]  = mk(0, 0, 0, 8'h00, 0, 3'b000, 0, 0, 3'b000, 8'h00, 0, 0);
    tv[2]  = mk(0, 1, 1, 8'h11, 0, 3'b000, 1, 1, 3'b010, 8'h11, 0, 0);
    tv[3]  = mk(0, 1, 3, 8'h22, 0, 3'b000, 1, 1, 3'b010, 8'h22, 0, 0);
    tv[4]  = mk(0, 1, 0, 8'h33, 1, 3'b000, 1, 1, 3'b010, 8'h33, 1, 0);
    tv[5]  = mk(0, 1, 1, 8'h44, 1, 3'b000, 1, 1, 3'b010, 8'h44, 1, 0);
    tv[6]  = mk(0, 1, 1, 8'h55, 1, 3'b000, 1, 0, 3'b000, 8'h00, 0, 0);
    tv[7]  = mk(0, 0, 1, 8'h55, 1, 3'b010, 0, 0, 3'b000, 8'h00, 0, 0);
    tv[8]  = mk(0, 1, 1, 8'h55, 1, 3'b010, 1, 1, 3'b010, 8'h55, 1, 0);
    tv[9]  = mk(0, 0, 0, 8'h00, 0, 3'b010, 0, 0, 3'b000, 8'h00, 0, 0);
    tv[10] = mk(0, 0, 0, 8'h00, 0, 3'b010, 0, 0, 3'b000, 8'h00, 0, 0);
    tv[11] = mk(0, 0, 0, 8'h00, 0, 3'b010, 0, 0, 3'b000, 8'h00, 0, 0);
    tv[12] = mk(0, 1, 0, 8'hA0, 1, 3'b000, 1, 1, 3'b001, 8'hA0, 1, 0);
    tv[13] = mk(0, 1, 0, 8'hA1, 1, 3'b000, 1, 1, 3'b001, 8'hA1, 1, 0);
    tv[14] = mk(0, 1, 0, 8'hA2, 1, 3'b000, 1, 1, 3'b001, 8'hA2, 1, 0);
    tv[15] = mk(0, 1, 0, 8'hA3, 1, 3'b000, 1, 1, 3'b001, 8'hA3, 1, 0);
    tv[16] = mk(0, 1, 0, 8'hA4, 1, 3'b000, 1, 0, 3'b000, 8'h00, 0, 0);
    tv[17] = mk(0, 1, 0, 8'hA4, 1, 3'b001, 1, 0, 3'b000, 8'h00, 0, 0);
    tv[18] = mk(0, 1, 0, 8'hA4, 1, 3'b000, 1, 1, 3'b001, 8'hA4, 1, 0);
    tv[19] = mk(0, 0, 0, 8'h00, 0, 3'b001, 0, 0, 3'b000, 8'h00, 0, 0);
    tv[20] = mk(0, 0, 0, 8'h00, 0, 3'b001, 0, 0, 3'b000, 8'h00, 0, 0);
    tv[21] = mk(0, 0, 0, 8'h00, 0, 3'b001, 0, 0, 3'b000, 8'h00, 0, 0);
    tv[22] = mk(0, 0, 0, 8'h00, 0, 3'b001, 0, 0, 3'b000, 8'h00, 0, 0);
    tv[23] = mk(0, 1, 3, 8'hB0, 0, 3'b000, 1, 1, 3'b000, 8'h00, 0, 0);
    tv[24] = mk(0, 1, 0, 8'hB1, 0, 3'b000, 1, 1, 3'b000, 8'h00, 0, 0);
    tv[25] = mk(0, 1, 1, 8'hB2, 0, 3'b000, 1, 1, 3'b000, 8'h00, 0, 0);
    tv[26] = mk(0, 1, 2, 8'hB3, 1, 3'b000, 1, 1, 3'b000, 8'h00, 0, 0);
    tv[27] = mk(0, 1, 2, 8'hB4, 1, 3'b000, 1, 1, 3'b100, 8'hB4, 1, 0);
    tv[28] = mk(0, 1, 0, 8'hC0, 1, 3'b000, 1, 1, 3'b001, 8'hC0, 1, 0);
    tv[29] = mk(0, 1, 1, 8'hC1, 1, 3'b000, 1, 1, 3'b010, 8'hC1, 1, 0);
    tv[30] = mk(0, 0, 0, 8'h00, 0, 3'b111, 0, 0, 3'b000, 8'h00, 0, 0);
    tv[31] = mk(0, 0, 0, 8'h00, 0, 3'b100, 0, 0, 3'b000, 8'h00, 0, 1);
    tv[32] = mk(0, 1, 0, 8'hD0, 1, 3'b000, 1, 1, 3'b001, 8'hD0, 1, 1);
    tv[33] = mk(0, 1, 2, 8'hE0, 0, 3'b000, 1, 1, 3'b100, 8'hE0, 0, 1);
    tv[34] = mk(1, 1, 2, 8'hE1, 0, 3'b111, 0, 0, 3'b000, 8'h00, 0, 0);
    tv[35] = mk(0, 1, 0, 8'hE2, 1, 3'b000, 1, 1, 3'b001, 8'hE2, 1, 0);
    tv[36] = mk(0, 0, 0, 8'h00, 0, 3'b001, 0, 0, 3'b000, 8'h00, 0, 0);
    tv[37] = mk(0, 0, 0, 8'h00, 0, 3'b001, 0, 0, 3'b000, 8'h00, 0, 1);
    tv[38] = mk(1, 0, 0, 8'h00, 0, 3'b000, 0, 0, 3'b000, 8'h00, 0, 0);
    tv[39] = mk(0, 1, 0, 8'hF0, 1, 3'b000, 1, 1, 3'b001, 8'hF0, 1, 0);
    tv[40] = mk(0, 1, 1, 8'hF1, 1, 3'b000, 1, 1, 3'b010, 8'hF1, 1, 0);
    tv[41] = mk(0, 1, 2, 8'hF2, 1, 3'b000, 1, 1, 3'b100, 8'hF2, 1, 0);
    tv[42] = mk(0, 0, 0, 8'h00, 0, 3'b000, 0, 0, 3'b000, 8'h00, 0, 0);

    for (int i = 0; i < 43; i++) begin
      @(negedge clk);
      rst = tv[i].r; in_valid = tv[i].v; in_port = tv[i].p; in_data = tv[i].d;
      in_last = tv[i].l; credit_ret = tv[i].ret;
      #1;
      if (tv[i].ck) chk("in_ready", i, 16'(in_ready), 16'(tv[i].rdy));
      @(posedge clk);
      #1;
      chk("out_valid", i, 16'(out_valid), 16'(tv[i].ov));
      chk("credit_err", i, 16'(credit_err), 16'(tv[i].err));
      if (tv[i].ov != 0 || tv[i].r) begin
        chk("out_data", i, 16'(out_data), 16'(tv[i].od));
        chk("out_last", i, 16'(out_last), 16'(tv[i].ol));
      end
`ifndef ROUTER_SCHED_STATS_EN
      chk("pkt_count", i, pkt_count, 16'h0000);
`endif
    end

`ifdef ROUTER_SCHED_STATS_EN
    @(negedge clk);
    rst = 1; in_valid = 0; credit_ret = 0;
    @(negedge clk);
    rst = 0; in_valid = 1; in_port = 0; in_last = 1; in_data = 8'h5A; credit_ret = 3'b001;
    repeat (65537) @(negedge clk);
    in_valid = 0; credit_ret = 0;
    @(posedge clk);
    #1;
    chk("pkt_count_wrap", 0, pkt_count, 16'h0001);
    chk("credit_err_wrap", 0, 16'(credit_err), 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
